wb_dmem_slave: RTL and testbench

- Wishbone slave data memory that sits directly downstream of the core's data-side bus adapter.
- Consumes the adapter's cyc/stb/we/sel/addr/data outputs and returns ack, err, rty and read data.
- The adapter holds its request until ack; it performs byte-lane steering, so this block only honours per-lane selects on word-aligned addresses.
- Programmable wait states let the pipeline stall path be exercised.

---
 rtl/wb_dmem_slave.sv | 159 +++++++++++++++
 tb/tb_wb_dmem_slave.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dmem_slave.sv
// wb_dmem_slave: Wishbone data memory behind the core's data-side adapter.
// Ports: clk_i, rst_i (async, active-low), wb_cyc_i/stb_i/we_i/addr_i/sel_i/data_i in;
//   wb_data_o, wb_ack_o, wb_err_o, wb_rty_o (tied 0) out.
// Option: define WB_DMEM_ERR_EN to error-terminate out-of-range accesses.

`ifndef AddressBusWidth
`define AddressBusWidth 32
`endif
`ifndef WordWidth
`define WordWidth 32
`endif

module wb_dmem_slave #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wb_cyc_i,
  input  logic                        wb_stb_i,
  input  logic                        wb_we_i,
  input  logic [`AddressBusWidth-1:0] wb_addr_i,
  input  logic [7:0]                  wb_sel_i,
  input  logic [`WordWidth-1:0]       wb_data_i,
  output logic [`WordWidth-1:0]       wb_data_o,
  output logic                        wb_ack_o,
  output logic                        wb_err_o,
  output logic                        wb_rty_o
);

  localparam int ABW   = `AddressBusWidth;
  localparam int DW    = `WordWidth;
  localparam int LANES = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0] cnt_q, cnt_d;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] data_q;

  logic          req;
  logic [AW-1:0] idx;
  logic          resp;
  logic          bad;
  logic          rd_hit;
  logic          wr_hit;

  assign req = wb_cyc_i & wb_stb_i;
  assign idx = wb_addr_i[AW+1:2];

`ifdef WB_DMEM_ERR_EN
  assign bad = |wb_addr_i[ABW-1:AW+2];

  logic unused_in;
  assign unused_in = ^{wb_sel_i[7:4], wb_addr_i[1:0]};
`else
  assign bad = 1'b0;

  // Upper address bits are dropped so accesses wrap modulo DEPTH.
  logic unused_in;
  assign unused_in = ^{wb_sel_i[7:4],
                       wb_addr_i[1:0],
                       wb_addr_i[ABW-1:AW+2]};
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        // Forced IDLE gap keeps a held strobe from being acked twice.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign resp   = (state_q == S_RESP);
  assign rd_hit = resp & ~wb_we_i & ~bad;
  assign wr_hit = resp &  wb_we_i & ~bad;

  assign wb_ack_o = resp & ~bad;
  assign wb_err_o = resp &  bad;
  assign wb_rty_o = 1'b0;

  // Read data flows straight from the array in RESP and is then held.
  assign wb_data_o = rd_hit ? mem[idx] : data_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_q <= '0;
    end else if (rd_hit) begin
      data_q <= mem[idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_hit) begin
      for (int k = 0; k < LANES; k++) begin
        if (wb_sel_i[k]) begin
          mem[idx][8*k +: 8] <= wb_data_i[8*k +: 8];
        end
      end
    end
  end

  a_one_term: assert property (
    @(posedge clk_i) disable iff (!rst_i)
    !(wb_ack_o && wb_err_o)
  );

  a_term_resp: assert property (
    @(posedge clk_i) disable iff (!rst_i)
    (wb_ack_o || wb_err_o) |-> resp
  );

endmodule

// File: tb/tb_wb_dmem_slave.sv
// tb_wb_dmem_slave: directed and random checks of wb_dmem_slave
// against a word-array reference model.

`ifndef AddressBusWidth
`define AddressBusWidth 32
`endif
`ifndef WordWidth
`define WordWidth 32
`endif

module tb_wb_dmem_slave;

  localparam int W     = 2;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2 + W;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        cyc   = 1'b0;
  logic        stb   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = '0;
  logic [7:0]  sel   = '0;
  logic [31:0] wdat  = '0;
  logic [31:0] rdat;
  logic        ack;
  logic        err;
  logic        rty;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] last_rd;

  wb_dmem_slave #(
    .DEPTH      (DEPTH),
    .WAIT_CYCLES(W),
    .AW         (10)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_addr_i(addr),
    .wb_sel_i (sel),
    .wb_data_i(wdat),
    .wb_data_o(rdat),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wb_rty_o (rty)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % 32'(DEPTH));
  endfunction

  function automatic logic is_oor(input logic [31:0] a);
`ifdef WB_DMEM_ERR_EN
    return a >= 32'(DEPTH * 4);
`else
    return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
  endfunction

  task automatic model_write(input logic [31:0] a,
                             input logic [7:0] s,
                             input logic [31:0] d);
    int i;
    i = widx(a);
    for (int k = 0; k < 4; k++)
      if (s[k]) model[i][8*k +: 8] = d[8*k +: 8];
  endtask

  task automatic access(input logic w,
                        input logic [31:0] a,
                        input logic [7:0] s,
                        input logic [31:0] d);
    int n;
    bit got;
    logic bad;
    logic [31:0] exp;
    bad = is_oor(a);
    exp = model[widx(a)];
    @(posedge clk_i); #1;
    cyc = 1'b1; stb = 1'b1;
    we = w; addr = a; sel = s; wdat = d;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk_i);
      n++;
      if (ack || err) got = 1'b1;
    end
    check("term_seen", 32'(got), 32'd1);
    check("latency", 32'(n), 32'(LAT));
    check("ack", 32'(ack), 32'(!bad));
    check("err", 32'(err), 32'(bad));
    check("rty", 32'(rty), 32'd0);
    if (!w && !bad) begin
      check("rdata", rdat, exp);
      last_rd = exp;
    end else begin
      check("rdata_kept", rdat, last_rd);
    end
    if (w && !bad) model_write(a, s, d);
    @(posedge clk_i); #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk_i);
    check("term_1cyc", 32'({ack, err}), 32'd0);
    check("data_hold", rdat, last_rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acks;
    int first;
    int second;
    bit got;
    logic [31:0] a;
    logic [31:0] hi;

    for (int i = 0; i < DEPTH; i++) model[i] = 'x;
    last_rd = '0;

    // Reset held with a live request pending.
    rst_i = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    addr = 32'h0; sel = 8'h0F; wdat = 32'h0BAD_F00D;
    repeat (3) begin
      @(negedge clk_i);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_data", rdat, 32'd0);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk_i);
      n++;
      if (ack) got = 1'b1;
    end
    check("rel_latency", 32'(n), 32'(LAT));
    model_write(32'h0, 8'h0F, 32'h0BAD_F00D);
    @(posedge clk_i); #1;
    cyc = 1'b0; stb = 1'b0;

    // Known contents for the low 16 words.
    for (int i = 0; i < 16; i++)
      access(1'b1, 32'(i * 4), 8'h0F, $urandom);

    // Full word write / read.
    access(1'b1, 32'h10, 8'h0F, 32'hDEAD_BEEF);
    access(1'b0, 32'h10, 8'h0F, 32'h0);
    check("full_rd", rdat, 32'hDEAD_BEEF);

    // Byte lanes.
    access(1'b1, 32'h10, 8'h04, 32'h5555_5555);
    access(1'b0, 32'h10, 8'h0F, 32'h0);
    check("lane_rd", rdat, 32'hDE55_BEEF);
    access(1'b1, 32'h10, 8'h00, 32'h1234_5678);
    access(1'b0, 32'h10, 8'h0F, 32'h0);
    check("sel0_rd", rdat, 32'hDE55_BEEF);

    // Held strobe across two reads.
    @(posedge clk_i); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    addr = 32'h0; sel = 8'h0F;
    acks = 0; first = 0; second = 0;
    for (int c = 1; c <= 2 * LAT + 4 && acks < 2; c++) begin
      @(negedge clk_i);
      if (ack) begin
        acks++;
        if (acks == 1) begin
          first = c;
          check("b2b_rd0", rdat, model[0]);
          @(posedge clk_i); #1;
          addr = 32'h4;
        end else begin
          second = c;
          check("b2b_rd1", rdat, model[1]);
        end
      end
    end
    @(posedge clk_i); #1;
    cyc = 1'b0; stb = 1'b0;
    last_rd = model[1];
    check("b2b_acks", 32'(acks), 32'd2);
    check("b2b_first", 32'(first), 32'(LAT));
    check("b2b_second", 32'(second), 32'(2 * LAT));
    @(negedge clk_i);
    check("b2b_after", 32'(ack), 32'd0);

    // Abort one cycle into WAIT.
    @(posedge clk_i); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    addr = 32'h14; sel = 8'h0F; wdat = 32'h1234_5678;
    @(negedge clk_i);
    @(negedge clk_i);
    @(posedge clk_i); #1;
    stb = 1'b0;
    acks = 0;
    repeat (2 * LAT) begin
      @(negedge clk_i);
      if (ack || err) acks++;
    end
    cyc = 1'b0;
    check("abort_noack", 32'(acks), 32'd0);
    access(1'b0, 32'h14, 8'h0F, 32'h0);

    // Reset in the middle of WAIT.
    @(posedge clk_i); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    addr = 32'h18; sel = 8'h0F; wdat = 32'hCAFE_F00D;
    @(negedge clk_i);
    @(negedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_data", rdat, 32'd0);
    last_rd = '0;
    acks = 0;
    repeat (2 * LAT) begin
      @(negedge clk_i);
      if (ack || err) acks++;
    end
    check("mid_rst_noack", 32'(acks), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    access(1'b0, 32'h18, 8'h0F, 32'h0);

    // Out of range.
    access(1'b1, 32'h0001_0000, 8'h0F, 32'hA5A5_A5A5);
    access(1'b0, 32'h0, 8'h0F, 32'h0);
`ifndef WB_DMEM_ERR_EN
    check("oor_wrap", rdat, 32'hA5A5_A5A5);
`endif

    // Random traffic on the initialised words.
    for (int i = 0; i < 40; i++) begin
      hi = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 15)) : 32'd0;
      a = (hi << 16) | 32'($urandom_range(0, 15) * 4)
        | 32'($urandom_range(0, 3));
      access(1'($urandom_range(0, 1)), a, 8'($urandom), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
